// File: rtl/hyperbus_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hyperbus_burst_ctrl
//  Description : HyperBus primary controller running linear bursts of
//                1..MAX_BURST words over a DDR PHY, 2*WIDTH bits per clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_burst_ctrl #(
    parameter  int WIDTH         = 8,
    parameter  int NUM_CS        = 2,
    parameter  int TACC_COUNT    = 6,
    parameter  int RESET_COUNT   = 2,
    parameter  int MAX_BURST     = 16,
    parameter  int TIMEOUT_COUNT = 64,
    parameter  int CSHI_COUNT    = 2,
    localparam int CS_W          = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int LEN_W         = $clog2(MAX_BURST + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic               cmd_reg,
    input  logic [CS_W-1:0]    cmd_cs,
    input  logic [31:0]        cmd_adr,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [2*WIDTH-1:0] wr_data,
    input  logic [1:0]         wr_mask,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic [2*WIDTH-1:0] rd_data,
    output logic               rd_valid,
    output logic               done,
    output logic               error,
    output logic [2*WIDTH-1:0] phy_dq_o,
    input  logic [2*WIDTH-1:0] phy_dq_i,
    output logic               phy_dq_oe,
    output logic [1:0]         phy_rwds_o,
    input  logic [1:0]         phy_rwds_i,
    output logic               phy_rwds_oe,
    output logic               phy_clk_en,
    output logic               hbus_rstn,
    output logic [NUM_CS-1:0]  hbus_csn
);

    localparam int CNT_W = 16;

    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_LAT   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_READ  = 3'd5;
    localparam logic [2:0] S_CSHI  = 3'd6;

    localparam logic [CNT_W-1:0] c_reset_last = CNT_W'(RESET_COUNT);
    localparam logic [CNT_W-1:0] c_cmd_last   = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_lat1_last  = CNT_W'(TACC_COUNT - 1);
    localparam logic [CNT_W-1:0] c_lat2_last  = CNT_W'(2 * TACC_COUNT - 1);
    localparam logic [CNT_W-1:0] c_tmo_last   = CNT_W'(TIMEOUT_COUNT - 1);
    localparam logic [CNT_W-1:0] c_cshi_last  = CNT_W'(CSHI_COUNT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [LEN_W-1:0] c_len_one    = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_len_max    = LEN_W'(MAX_BURST);
    localparam logic [CS_W:0]    c_num_cs     = (CS_W + 1)'(NUM_CS);

    logic [2:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [LEN_W-1:0] r_words, w_words_nxt;
    logic             r_lat2x, w_lat2x_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
    logic             r_we, r_reg;
    logic [CS_W-1:0]  r_cs;
    logic [31:0]      r_adr;
    logic [LEN_W-1:0] r_len;
    logic [2*WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    logic             w_accept;
    logic             w_bad_cs;
    logic             w_reg_wr;
    logic             w_last_word;
    logic             w_strobe;
    logic             w_bus_active;
    logic [LEN_W-1:0] w_len_eff;
    logic [47:0]      w_ca;
    logic [15:0]      w_ca_word;

    assign w_bad_cs     = ({1'b0, cmd_cs} >= c_num_cs);
    assign w_reg_wr     = r_reg & r_we;
    assign w_last_word  = (r_words == (r_len - c_len_one));
    assign w_strobe     = (r_state == S_READ) && (phy_rwds_i == 2'b01);
    assign w_bus_active = (r_state == S_CMD) || (r_state == S_LAT) ||
                          (r_state == S_WRITE) || (r_state == S_READ);
    assign w_ca         = {~r_we, r_reg, 1'b1, r_adr[31:3], 13'd0, r_adr[2:0]};

    always_comb begin
        w_len_eff = cmd_len;
        if (cmd_reg && cmd_we) begin
            w_len_eff = c_len_one;
        end else if (cmd_len == '0) begin
            w_len_eff = c_len_one;
        end else if (cmd_len > c_len_max) begin
            w_len_eff = c_len_max;
        end
    end

    always_comb begin
        case (r_cnt[1:0])
            2'd0:    w_ca_word = w_ca[47:32];
            2'd1:    w_ca_word = w_ca[31:16];
            default: w_ca_word = w_ca[15:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RESET;
            r_cnt      <= '0;
            r_words    <= '0;
            r_lat2x    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_we       <= 1'b0;
            r_reg      <= 1'b0;
            r_cs       <= '0;
            r_adr      <= '0;
            r_len      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_words    <= w_words_nxt;
            r_lat2x    <= w_lat2x_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_rd_valid <= w_strobe;
            if (w_strobe) begin
                r_rd_data <= phy_dq_i;
            end
            if (w_accept) begin
                r_we  <= cmd_we;
                r_reg <= cmd_reg;
                r_cs  <= cmd_cs;
                r_adr <= cmd_adr;
                r_len <= w_len_eff;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_one;
        w_words_nxt = r_words;
        w_lat2x_nxt = r_lat2x;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_RESET: begin
                if (r_cnt == c_reset_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_words_nxt = '0;
                    w_lat2x_nxt = 1'b0;
                    if (w_bad_cs) begin
                        w_state_nxt = S_CSHI;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_CMD;
                    end
                end
            end
            S_CMD: begin
                // Device asks for doubled latency by driving RWDS high during CA
                if (phy_rwds_i == 2'b11) begin
                    w_lat2x_nxt = 1'b1;
                end
                if (r_cnt == c_cmd_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_reg_wr ? S_WRITE : S_LAT;
                end
            end
            S_LAT: begin
                if (r_cnt == (r_lat2x ? c_lat2_last : c_lat1_last)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                w_cnt_nxt = '0;
                if (wr_valid) begin
                    w_words_nxt = r_words + c_len_one;
                    if (w_last_word) begin
                        w_state_nxt = S_CSHI;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (w_strobe) begin
                    w_cnt_nxt   = '0;
                    w_words_nxt = r_words + c_len_one;
                    if (w_last_word) begin
                        w_state_nxt = S_CSHI;
                        w_done_nxt  = 1'b1;
                    end
                end else if (r_cnt == c_tmo_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CSHI;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                end
            end
            S_CSHI: begin
                if (r_cnt == c_cshi_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_RESET;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        cmd_ready   = (r_state == S_IDLE);
        wr_ready    = (r_state == S_WRITE) && wr_valid;
        phy_dq_oe   = (r_state == S_CMD) || (r_state == S_WRITE);
        phy_rwds_oe = (r_state == S_WRITE) && !w_reg_wr;
        phy_rwds_o  = 2'b00;
        phy_dq_o    = '0;
        phy_clk_en  = (r_state == S_CMD) || (r_state == S_LAT) || (r_state == S_READ);
        hbus_rstn   = (r_state != S_RESET);
        if (r_state == S_CMD) begin
            phy_dq_o = (2*WIDTH)'(w_ca_word);
        end
        if (r_state == S_WRITE) begin
            phy_dq_o   = wr_data;
            phy_clk_en = wr_valid;
            if (!w_reg_wr) begin
                phy_rwds_o = wr_mask;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign done     = r_done;
    assign error    = r_err;

    generate
        for (genvar i = 0; i < NUM_CS; i++) begin : g_csn
            assign hbus_csn[i] = ~(w_bus_active && (r_cs == CS_W'(i)));
        end
    endgenerate

endmodule
`default_nettype wire
